wb_trace_fifo: RTL
==================

Name: wb_trace_fifo

Overview:
- Passive observer on the processor's register-file write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg).
- Captures every qualifying write-back as a tagged trace record in a FIFO.
- Records drain through a valid/ready interface to a checker or host.
- Read-side counterpart of the processor's regfile writer; lets benches and on-chip debug compare execution against a golden write-back stream.

Parameters:
DEPTH, 16, FIFO entries; must be a power of two, 2..256
ADDR_W, 4, log2(DEPTH)
DROP_R0, 1, 1 = ignore writes to register 0; 0 = record them

Ports:
clock  input  1  single system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
ctrl_writeEnable  input  1  regfile write strobe from the processor
ctrl_writeReg  input  5  destination register of the write
data_writeReg  input  32  data being written
clear  input  1  synchronous flush
trace_ready  input  1  consumer accepts the head record
trace_valid  output  1  head record available
trace_reg  output  5  head record register number
trace_data  output  32  head record data
trace_seq  output  16  head record sequence tag
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky; a record was dropped because the FIFO was full
drop_count  output  16  number of dropped records; saturates at 0xFFFF

Behaviour:
- Reset (reset=0, asynchronous): pointers, count, seq counter, overflow and drop_count go to 0; trace_valid=0. trace_reg/trace_data/trace_seq read 0 while empty.
- Qualifying event: rising edge with ctrl_writeEnable=1, and ctrl_writeReg!=0 when DROP_R0=1.
- Sequence tag:
  - Every qualifying event receives the current seq value; seq then increments mod 2^16.
  - Dropped events also consume a tag, so the consumer sees gaps in the tag sequence.
- Push: qualifying event and not full writes {seq, reg, data} at the write pointer, which then advances and wraps at DEPTH.
- Pop: trace_valid && trace_ready; the read pointer advances and wraps.
- Output mode is first-word-fall-through:
  - trace_* always present the head entry.
  - trace_valid = (count!=0).
  - Capture-to-valid latency is 1 cycle: an event at edge N is visible after edge N.
- Full (count==DEPTH):
  - If a pop occurs in the same cycle, the push is accepted and count is unchanged.
  - Otherwise the event is dropped: overflow←1, drop_count increments unless already 0xFFFF.
- Empty: trace_ready is ignored and there is no pop. Push and pop in the same cycle cannot both occur when empty, because valid is 0.
- Simultaneous push and pop when neither full nor empty: both pointers advance and count is unchanged.
- Count update: +1 on push only, −1 on pop only.
- clear=1:
  - Next edge sets pointers, count, seq, overflow and drop_count to 0.
  - Overrides any push or pop in the same cycle; the concurrent event is discarded without a tag.
- reset asserted mid-stream: immediate return to reset state; buffered records are lost.
- Memory: a plain register array with no reset requirement on contents. Outputs are masked to 0 when empty.
- Trace inputs are sampled only on clock edges. ctrl_writeEnable glitches between edges are not recorded.

Test Plan:
- Reset then idle 5 cycles with trace_ready=1 -> trace_valid=0, count=0, overflow=0, drop_count=0, all trace outputs 0.
- Writes (r1,0x00000005), (r0,0xFFFFFFFF), (r2,0x0000000A) on consecutive edges, DROP_R0=1, trace_ready=0 -> count=2. Head shows reg=1, data=5, seq=0. After one pop: reg=2, data=0xA, seq=1.
- 20 consecutive writes to r3 with data 1..20, DEPTH=16, trace_ready=0 -> count=16, overflow=1, drop_count=4. Draining yields data 1..16 with seq 0..15. The next write gets seq 20.
- FIFO full, write (r4,0x1234) in the same cycle as trace_ready=1 -> push accepted, count stays 16. The record is last out, with seq 16 if no prior drops.
- 8 records buffered, clear=1 concurrent with write (r5,0x99) and trace_ready=1 -> next cycle count=0, trace_valid=0. The following write gets seq 0.
- 3 records buffered, reset driven low between edges -> trace_valid, count and overflow drop to 0 immediately without a clock edge. After release, the first write gets seq 0.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// Passive write-back tracer: captures register-file writes as tagged records
// in a first-word-fall-through FIFO drained through a valid/ready port.
module wb_trace_fifo #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter bit          DROP_R0 = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ctrl_writeEnable,
    input  logic [4:0]        ctrl_writeReg,
    input  logic [31:0]       data_writeReg,
    input  logic              clear,
    input  logic              trace_ready,
    output logic              trace_valid,
    output logic [4:0]        trace_reg,
    output logic [31:0]       trace_data,
    output logic [15:0]       trace_seq,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [15:0]       drop_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef struct packed {
        logic [15:0] seq;
        logic [4:0]  rd;
        logic [31:0] data;
    } rec_t;

    rec_t              mem [0:DEPTH-1];
    rec_t              head;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [15:0]       seq;
    logic              qualify;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    // Event qualification and push/pop arbitration; a pop frees room for a push when full.
    always_comb begin
        qualify = ctrl_writeEnable && (!DROP_R0 || (ctrl_writeReg != 5'd0));
        full    = (count == CNT_W'(DEPTH));
        pop     = trace_valid && trace_ready;
        push    = qualify && (!full || pop);
        drop    = qualify && full && !pop;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (qualify) begin
                seq <= seq + 16'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    // Record storage has no reset; unread contents are masked at the output.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            mem[wr_ptr] <= '{seq: seq, rd: ctrl_writeReg, data: data_writeReg};
        end
    end

    always_comb begin
        head        = mem[rd_ptr];
        trace_valid = (count != '0);
        trace_reg   = '0;
        trace_data  = '0;
        trace_seq   = '0;
        if (trace_valid) begin
            trace_reg  = head.rd;
            trace_data = head.data;
            trace_seq  = head.seq;
        end
    end

endmodule
